// File: rtl/gpio_spi_pkg.sv
// Shared constants and FSM encoding for the SPI-to-GPIO register controller.
package gpio_spi_pkg;

  localparam logic [1:0] ADDR_DIR = 2'd0;
  localparam logic [1:0] ADDR_OUT = 2'd1;
  localparam logic [1:0] ADDR_IN  = 2'd2;
  localparam logic [1:0] ADDR_AUX = 2'd3;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_LEN    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchronizer for one asynchronous bit with single-cycle rise/fall pulses.
// Pulses appear STAGES clk after the pad edge; no flow control.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      q_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      q_d    <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/gpio_spi_ctrl.sv
// SPI mode-0 slave decoding CMD+DATA frames into GPIO direction/drive register writes.
// Optional pending-edge interrupt register at address 3 when GPIO_IRQ_EN is defined.
module gpio_spi_ctrl
  import gpio_spi_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ID_VALUE    = 16'h1C02
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_clk,
  input  logic             spi_en,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] gpio_input,
  output logic [WIDTH-1:0] gpio_ts,
  output logic [WIDTH-1:0] gpio_dr
`ifdef GPIO_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int CW = $clog2(WIDTH + CMD_LEN);
  localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic en_q, en_rise, en_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(spi_clk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_en_sync (
    .clk(clk), .rst(rst), .d(spi_en), .q(en_q), .rise(en_rise), .fall(en_fall)
  );

  logic [SYNC_STAGES-1:0]            mosi_sync;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] gin_sync;
  logic                              mosi_s;
  logic [WIDTH-1:0]                  gin_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync <= '0;
      gin_sync  <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      gin_sync  <= {gin_sync[SYNC_STAGES-2:0], gpio_input};
    end
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign gin_s  = gin_sync[SYNC_STAGES-1];

  state_t           state, state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_sr, tx_sr, rd_data;
  logic [1:0]       cmd_addr, rd_addr;
  logic             cmd_rd, commit;
  logic             shift, cmd_done, data_done;

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] pend, pend_nxt, pend_clr, gin_prev;
`endif

  // Clock edges only count while the synced enable is still high.
  assign shift     = sclk_rise & en_q;
  assign cmd_done  = shift && (bit_cnt == CMD_LAST);
  assign data_done = shift && (bit_cnt == DATA_LAST);
  assign rd_addr   = {rx_sr[0], mosi_s};

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_DIR: rd_data = gpio_ts;
      ADDR_OUT: rd_data = gpio_dr;
      ADDR_IN:  rd_data = gin_s;
`ifdef GPIO_IRQ_EN
      default:  rd_data = pend;
`else
      default:  rd_data = WIDTH'(ID_VALUE);
`endif
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en_rise && !sclk_q) state_nxt = CMD;
      CMD:  if (en_fall) state_nxt = IDLE; else if (cmd_done) state_nxt = DATA;
      DATA: if (en_fall) state_nxt = IDLE; else if (data_done) state_nxt = DONE;
      DONE: if (en_fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      cmd_addr <= '0;
      cmd_rd   <= 1'b0;
      commit   <= 1'b0;
      miso     <= 1'b0;
      gpio_ts  <= '1;
      gpio_dr  <= '0;
    end else begin
      commit <= 1'b0;
      case (state)
        CMD: begin
          miso <= 1'b0;
          if (shift) begin
            rx_sr   <= {rx_sr[WIDTH-2:0], mosi_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (cmd_done) begin
              // rx_sr holds the first seven CMD bits; mosi_s is CMD[0].
              cmd_rd   <= rx_sr[CMD_RW_BIT-1];
              cmd_addr <= rd_addr;
              tx_sr    <= rd_data;
              bit_cnt  <= '0;
            end
          end
        end
        DATA: begin
          if (en_fall) begin
            miso <= 1'b0;
          end else if (shift) begin
            rx_sr   <= {rx_sr[WIDTH-2:0], mosi_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (data_done) begin
              miso   <= 1'b0;
              commit <= ~cmd_rd;
            end
          end else if (sclk_fall) begin
            miso  <= tx_sr[WIDTH-1];
            tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
          end
        end
        default: begin
          bit_cnt <= '0;
          miso    <= 1'b0;
        end
      endcase

      if (commit) begin
        case (cmd_addr)
          ADDR_DIR: gpio_ts <= rx_sr;
          ADDR_OUT: gpio_dr <= rx_sr;
          default: ;
        endcase
      end
    end
  end

`ifdef GPIO_IRQ_EN
  // A new edge in the same cycle as a W1C clear keeps the bit set.
  always_comb begin
    pend_clr = (commit && cmd_addr == ADDR_AUX) ? rx_sr : '0;
    pend_nxt = (pend & ~pend_clr) | (gin_s & ~gin_prev & gpio_ts);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      gin_prev <= '0;
      irq      <= 1'b0;
    end else begin
      pend     <= pend_nxt;
      gin_prev <= gin_s;
      irq      <= |pend_nxt;
    end
  end
`endif

endmodule
